// File: rtl/otter_iobus_uart_tx.sv
// OTTER IOBUS transmit-only UART: TXDATA/STATUS/CTRL window, byte FIFO, 8N1 framer.
// Define UART_TX_INTR_EN to build the IE bit and the transmit-drained INTR pulse.
module otter_iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX,
  output logic        INTR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q, en_q, ie;

  logic sel_tx, sel_st, sel_ct;
  logic empty, full, push, pop;
  logic stop_done, bit_end;

  assign sel_tx  = IOBUS_ADDR == BASE_ADDR;
  assign sel_st  = IOBUS_ADDR == BASE_ADDR + 32'd4;
  assign sel_ct  = IOBUS_ADDR == BASE_ADDR + 32'd8;
  assign empty   = count_q == '0;
  assign full    = count_q == DEPTH;
  assign bit_end = cnt_q == CNT_MAX;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push    = IOBUS_WR && sel_tx && (!full || pop);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    pop       = 1'b0;
    stop_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_q && !empty) begin
          state_d = START;
          pop     = 1'b1;
          cnt_d   = '0;
        end
      end
      START: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_end) begin
          stop_done = 1'b1;
          cnt_d     = '0;
          if (en_q && !empty) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    shift_d = pop ? mem[rd_ptr] : shift_q;
    // TX is registered from the next state so it moves on the transition edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (IOBUS_WR && sel_tx && full && !pop)
        ovf_q <= 1'b1;
      else if (IOBUS_WR && sel_st && IOBUS_OUT[3])
        ovf_q <= 1'b0;
    end
  end

`ifdef UART_TX_INTR_EN
  logic ie_q, intr_q;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      if (IOBUS_WR && sel_ct) begin
        en_q <= IOBUS_OUT[0];
        ie_q <= IOBUS_OUT[1];
      end
      intr_q <= stop_done && empty && ie_q;
    end
  end

  assign ie   = ie_q;
  assign INTR = intr_q;
`else
  logic unused_stop;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                  en_q <= 1'b0;
    else if (IOBUS_WR && sel_ct) en_q <= IOBUS_OUT[0];
  end

  assign ie          = 1'b0;
  assign INTR        = 1'b0;
  assign unused_stop = stop_done;
`endif

  logic unused_out;
  assign unused_out = ^IOBUS_OUT[31:8];

  always_comb begin
    IOBUS_IN = '0;
    unique case (1'b1)
      sel_st: IOBUS_IN = {8'h00, 8'(count_q), 12'h000,
                          ovf_q, empty, full, state_q != IDLE};
      sel_ct: IOBUS_IN = {30'd0, ie, en_q};
      default: IOBUS_IN = '0;
    endcase
  end

  assign TX = tx_q;

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// Self-checking bench for otter_iobus_uart_tx with a frame-schedule model.
// Honours UART_TX_INTR_EN for the interrupt expectations.
module tb_otter_iobus_uart_tx;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_CT  = BASE + 32'd8;
  localparam int          CPB   = 16;
  localparam int          FRAME = 10 * CPB;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] IOBUS_ADDR = A_ST;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        TX;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_a [16];
  int         gap_a  [16];
  int         nb;
  int         slen;
  bit         model_ie = 1'b0;
  logic obs_tx [4096];
  logic obs_bv [4096];
  logic obs_busy [4096];
  logic obs_intr [4096];
  logic exp_tx [4096];
  logic exp_busy [4096];
  logic exp_intr [4096];

  always #5 CLOCK = ~CLOCK;

  otter_iobus_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN),
    .TX(TX),
    .INTR(INTR)
  );

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(negedge CLOCK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = A_ST;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLOCK);
    IOBUS_ADDR = a;
    #1 d = IOBUS_IN;
  endtask

  // Frame i starts at max(write+1, previous start + FRAME); cycle index 0
  // is the edge after the first write. Drives writes and records the line.
  task automatic run_stream();
    int e [16];
    int s [16];
    e[0] = -1;
    s[0] = 0;
    for (int i = 1; i < nb; i++) begin
      e[i] = e[i-1] + 1 + gap_a[i];
      s[i] = (e[i] + 1 > s[i-1] + FRAME) ? e[i] + 1 : s[i-1] + FRAME;
    end
    slen = s[nb-1] + FRAME + 20;
    for (int c = 0; c < slen; c++) begin
      exp_tx[c]   = 1'b1;
      exp_busy[c] = 1'b0;
      exp_intr[c] = 1'b0;
    end
    for (int i = 0; i < nb; i++) begin
      for (int c = s[i]; c < s[i] + FRAME; c++) begin
        int p;
        p = (c - s[i]) / CPB;
        exp_busy[c] = 1'b1;
        if (p == 0)      exp_tx[c] = 1'b0;
        else if (p == 9) exp_tx[c] = 1'b1;
        else             exp_tx[c] = byte_a[i][p-1];
      end
      if (model_ie && !(i + 1 < nb && s[i+1] == s[i] + FRAME))
        exp_intr[s[i] + FRAME] = 1'b1;
    end
    @(negedge CLOCK);
    IOBUS_ADDR     = A_TX;
    IOBUS_OUT      = $urandom;
    IOBUS_OUT[7:0] = byte_a[0];
    IOBUS_WR       = 1'b1;
    for (int k = 0; k <= slen; k++) begin
      @(posedge CLOCK);
      #1;
      if (k >= 1) begin
        obs_tx[k-1]   = TX;
        obs_intr[k-1] = INTR;
        obs_bv[k-1]   = !IOBUS_WR;
        obs_busy[k-1] = IOBUS_IN[0];
      end
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = A_ST;
      for (int j = 1; j < nb; j++) begin
        if (e[j] == k) begin
          IOBUS_ADDR     = A_TX;
          IOBUS_OUT      = $urandom;
          IOBUS_OUT[7:0] = byte_a[j];
          IOBUS_WR       = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge CLOCK);
    checks++;
    if (TX !== 1'b1 || INTR !== 1'b0) begin
      errors++;
      $display("FAIL reset_lines TX=%b INTR=%b exp 1/0", TX, INTR);
    end
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL reset_status got %h exp 00000004", d);
    end
    RESET = 1'b1;
    rd_reg(A_CT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl got %h exp 0", d);
    end
    repeat (20) @(negedge CLOCK);
    checks++;
    if (TX !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_tx got %b exp 1", TX);
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] d;
    wr_reg(A_CT, 32'h1);
    rd_reg(BASE + 32'd12, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL bad_read got %h exp 0", d);
    end
    wr_reg(BASE + 32'd16, 32'hFFFF_FFFF);
    wr_reg(BASE + 32'd12, 32'hFFFF_FFFF);
    repeat (4) @(negedge CLOCK);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004 || TX !== 1'b1) begin
      errors++;
      $display("FAIL bad_write_status got %h tx %b exp 00000004 1", d, TX);
    end
    rd_reg(A_CT, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL bad_write_ctrl got %h exp 1", d);
    end
  endtask

  task automatic test_single_a5();
    int busy_n;
    wr_reg(A_CT, 32'h1);
    nb = 1;
    byte_a[0] = 8'hA5;
    run_stream();
    busy_n = 0;
    for (int c = 0; c < slen; c++) begin
      checks++;
      if (obs_tx[c] !== exp_tx[c]) begin
        errors++;
        $display("FAIL a5_tx c=%0d got %b exp %b", c, obs_tx[c], exp_tx[c]);
      end
      if (obs_bv[c] && obs_busy[c]) busy_n++;
    end
    checks++;
    if (busy_n != FRAME) begin
      errors++;
      $display("FAIL a5_busy_cycles got %0d exp %0d", busy_n, FRAME);
    end
  endtask

  task automatic test_two_frames();
    nb = 2;
    byte_a[0] = 8'h55;
    byte_a[1] = 8'hFF;
    gap_a[1]  = 0;
    run_stream();
    for (int c = 0; c < slen; c++) begin
      checks++;
      if (obs_tx[c] !== exp_tx[c]) begin
        errors++;
        $display("FAIL two_tx c=%0d got %b exp %b", c, obs_tx[c], exp_tx[c]);
      end
      if (obs_bv[c]) begin
        checks++;
        if (obs_busy[c] !== exp_busy[c]) begin
          errors++;
          $display("FAIL two_busy c=%0d got %b exp %b",
                   c, obs_busy[c], exp_busy[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    nb = 9;
    for (int i = 0; i < 9; i++) begin
      byte_a[i] = 8'(i);
      gap_a[i]  = 0;
    end
    run_stream();
    for (int c = 0; c < slen; c++) begin
      checks++;
      if (obs_tx[c] !== exp_tx[c]) begin
        errors++;
        $display("FAIL b2b_tx c=%0d got %b exp %b", c, obs_tx[c], exp_tx[c]);
      end
      if (obs_bv[c]) begin
        checks++;
        if (obs_busy[c] !== exp_busy[c]) begin
          errors++;
          $display("FAIL b2b_busy c=%0d got %b exp %b",
                   c, obs_busy[c], exp_busy[c]);
        end
      end
    end
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL b2b_status got %h exp 00000004", d);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        byte_a[i] = 8'($urandom);
        case ($urandom_range(0, 2))
          0:       gap_a[i] = 0;
          1:       gap_a[i] = $urandom_range(FRAME - 3, FRAME + 3);
          default: gap_a[i] = $urandom_range(0, 300);
        endcase
      end
      run_stream();
      for (int c = 0; c < slen; c++) begin
        checks++;
        if (obs_tx[c] !== exp_tx[c]) begin
          errors++;
          $display("FAIL rnd_tx r=%0d c=%0d got %b exp %b",
                   r, c, obs_tx[c], exp_tx[c]);
        end
        if (obs_bv[c]) begin
          checks++;
          if (obs_busy[c] !== exp_busy[c]) begin
            errors++;
            $display("FAIL rnd_busy r=%0d c=%0d got %b exp %b",
                     r, c, obs_busy[c], exp_busy[c]);
          end
        end
      end
    end
  endtask

  task automatic test_en_clear();
    logic [31:0] d;
    bit done;
    wr_reg(A_TX, 32'h0000_00C3);
    wr_reg(A_TX, 32'h0000_003C);
    repeat (40) @(negedge CLOCK);
    wr_reg(A_CT, 32'h0);
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      rd_reg(A_ST, d);
      if (d[0] == 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL en_clear_stop got %h done %0d exp 00010000", d, done);
    end
    repeat (50) @(negedge CLOCK);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0001_0000 || TX !== 1'b1) begin
      errors++;
      $display("FAIL en_clear_hold got %h tx %b exp 00010000 1", d, TX);
    end
    wr_reg(A_CT, 32'h1);
    repeat (FRAME + 20) @(negedge CLOCK);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL en_clear_drain got %h exp 00000004", d);
    end
  endtask

  task automatic test_intr();
    logic [31:0] d;
    logic [31:0] exp_ctrl;
    int pulses;
    int exp_pulses;
`ifdef UART_TX_INTR_EN
    model_ie   = 1'b1;
    exp_ctrl   = 32'h3;
    exp_pulses = 1;
`else
    model_ie   = 1'b0;
    exp_ctrl   = 32'h1;
    exp_pulses = 0;
`endif
    wr_reg(A_CT, 32'h3);
    rd_reg(A_CT, d);
    checks++;
    if (d !== exp_ctrl) begin
      errors++;
      $display("FAIL intr_ctrl got %h exp %h", d, exp_ctrl);
    end
    nb = 1;
    byte_a[0] = 8'($urandom);
    run_stream();
    pulses = 0;
    for (int c = 0; c < slen; c++) begin
      if (obs_intr[c] === 1'b1) pulses++;
      checks++;
      if (obs_intr[c] !== exp_intr[c]) begin
        errors++;
        $display("FAIL intr_line c=%0d got %b exp %b",
                 c, obs_intr[c], exp_intr[c]);
      end
    end
    checks++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL intr_pulses got %0d exp %0d", pulses, exp_pulses);
    end
    model_ie = 1'b0;
    wr_reg(A_CT, 32'h1);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr_reg(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) wr_reg(A_TX, 32'(i));
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0008_000A) begin
      errors++;
      $display("FAIL ovf_status got %h exp 0008000A", d);
    end
    wr_reg(A_ST, 32'hFFFF_FFF7);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0008_000A) begin
      errors++;
      $display("FAIL ovf_keep got %h exp 0008000A", d);
    end
    wr_reg(A_ST, 32'h8);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0008_0002) begin
      errors++;
      $display("FAIL ovf_clear got %h exp 00080002", d);
    end
    @(negedge CLOCK);
    IOBUS_ADDR = A_CT;
    IOBUS_OUT  = 32'h1;
    IOBUS_WR   = 1'b1;
    @(negedge CLOCK);
    IOBUS_ADDR = A_TX;
    IOBUS_OUT  = 32'h99;
    @(negedge CLOCK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = A_ST;
    #1;
    checks++;
    if (IOBUS_IN !== 32'h0008_0003) begin
      errors++;
      $display("FAIL full_push_pop got %h exp 00080003", IOBUS_IN);
    end
    repeat (9 * FRAME + 20) @(negedge CLOCK);
    rd_reg(A_ST, d);
    checks++;
    if (d !== 32'h0000_0004) begin
      errors++;
      $display("FAIL ovf_drain got %h exp 00000004", d);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int edges;
    logic prev;
    wr_reg(A_CT, 32'h1);
    wr_reg(A_TX, 32'hA5);
    repeat (88) @(posedge CLOCK);
    #2;
    checks++;
    if (TX !== 1'b0) begin
      errors++;
      $display("FAIL midframe_bit4 got %b exp 0", TX);
    end
    RESET = 1'b0;
    #1;
    checks++;
    if (TX !== 1'b1 || INTR !== 1'b0 || IOBUS_IN !== 32'h0000_0004) begin
      errors++;
      $display("FAIL midframe_reset tx %b intr %b st %h exp 1 0 00000004",
               TX, INTR, IOBUS_IN);
    end
    repeat (5) @(negedge CLOCK);
    RESET = 1'b1;
    rd_reg(A_CT, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL midframe_ctrl got %h exp 0", d);
    end
    wr_reg(A_TX, 32'h3C);
    edges = 0;
    prev  = TX;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK);
      if (TX !== prev) edges++;
      prev = TX;
    end
    rd_reg(A_ST, d);
    checks++;
    if (edges != 0 || TX !== 1'b1 || d !== 32'h0001_0000) begin
      errors++;
      $display("FAIL post_reset_idle edges %0d tx %b st %h exp 0 1 00010000",
               edges, TX, d);
    end
  endtask

  initial begin
    test_reset();
    test_bad_addr();
    test_single_a5();
    test_two_frames();
    test_back_to_back();
    test_random();
    test_en_clear();
    test_intr();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_iobus_uart_tx.md
OTTER_IOBUS_UART_TX -- requirements
Module: otter_iobus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1100_0100, word-aligned base of the 3-register window.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, CLOCK cycles per serial bit, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, power of two, legal range 2..64.
REQ-004 SHALL have port CLOCK  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port IOBUS_ADDR  input  32  byte address from the MCU.
REQ-007 SHALL have port IOBUS_OUT  input  32  write data from the MCU.
REQ-008 SHALL have port IOBUS_WR  input  1  write strobe, one cycle per write.
REQ-009 SHALL have port IOBUS_IN  output  32  read data to the MCU.
REQ-010 SHALL have port TX  output  1  serial line, idle high, registered.
REQ-011 SHALL have port INTR  output  1  transmit-drained interrupt pulse, registered.

Function
REQ-012 SHALL decode BASE+0 TXDATA (W), BASE+4 STATUS (R/W1C), BASE+8 CTRL (R/W); any other address is ignored on write and reads 0.
REQ-013 Write to TXDATA SHALL push IOBUS_OUT[7:0] into the FIFO at that edge when not full; when full, the byte is dropped and STATUS[3] OVF is set.
REQ-014 STATUS SHALL read {count in [23:16], 12'b0, OVF[3], EMPTY[2], FULL[1], BUSY[0]}; BUSY = FSM not in IDLE.
REQ-015 Write to STATUS with IOBUS_OUT[3]=1 SHALL clear OVF; other STATUS bits ignore writes.
REQ-016 CTRL[0] EN and CTRL[1] IE SHALL be read/write; other bits read 0.
REQ-017 IOBUS_IN SHALL be combinational from IOBUS_ADDR and current register state (zero-wait read).
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP; each bit held exactly CLKS_PER_BIT cycles.
REQ-019 IDLE->START when EN=1 and FIFO non-empty; pop occurs on that same edge; TX falls on that edge (one cycle after the capturing write edge).
REQ-020 DATA SHALL send 8 bits LSB first, bit counter 0..7, then STOP (TX=1).
REQ-021 At STOP end, if EN=1 and FIFO non-empty, FSM SHALL go directly to START with zero idle cycles; else IDLE.
REQ-022 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-023 Clearing EN mid-frame SHALL let the current frame complete; no new frame starts.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and accept the push even when full.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

Reset
REQ-026 Reset assertion SHALL immediately force FSM=IDLE, TX=1, INTR=0, FIFO empty (count 0), OVF=0, EN=0, IE=0, bit/cycle counters 0, including mid-frame.
REQ-027 Reset deassertion SHALL take effect on the next rising CLOCK edge; no frame starts until EN is written 1.

Configuration
REQ-028 Macro UART_TX_INTR_EN defined: INTR SHALL pulse high one cycle after the STOP bit ends with FIFO empty and IE=1.
REQ-029 Macro UART_TX_INTR_EN undefined: INTR SHALL be constant 0, IE not implemented (CTRL[1] reads 0, writes ignored).

Verification
REQ-030 Reset, write CTRL=1, write TXDATA=8'hA5, CLKS_PER_BIT=16 -> TX low 16 cycles, then 1,0,1,0,0,1,0,1 each 16 cycles, high 16 cycles; BUSY=1 for 160 cycles.
REQ-031 EN=1, write 9 bytes 8'h00..8'h08 back-to-back with FIFO_DEPTH=8 -> first byte pops after one cycle, all 9 sent contiguously, OVF=0; repeat with EN=0 -> 9th dropped, STATUS reads count 8, FULL=1, OVF=1; write STATUS=8 -> OVF=0.
REQ-032 Two queued bytes 8'h55, 8'hFF -> second START begins the cycle after first STOP ends; 20*CLKS_PER_BIT total busy cycles.
REQ-033 Assert RESET at bit 4 of a frame -> TX=1 and STATUS reads 32'h0000_0004 immediately, no further transitions.
REQ-034 With UART_TX_INTR_EN, CTRL=3, one byte -> single INTR pulse one cycle after STOP; without macro, same stimulus -> INTR stays 0, CTRL reads 1.
REQ-035 Read BASE+12 and write BASE+16 -> IOBUS_IN=0, no state change.
